i2c_bridge_ctrl: RTL and testbench

Parametrised successor to the single-bus UART-to-I2C command controller. It sits between the UART RX FIFO and the i2c_master, and drives the response FIFO that feeds uart_tx_ctrl. It parses framed commands (sync, control, address, length, payload) and buffers write payloads locally before starting a transfer. It steers one of NUM_BUS I2C buses and appends a status byte to every response, with both watchdog (transaction) timeouts and partial-frame timeouts.

---
 rtl/i2c_bridge_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_i2c_bridge_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bridge_ctrl.sv
// rtl/i2c_bridge_ctrl.sv - framed UART command parser driving one of NUM_BUS I2C buses
// Parses SYNC/CTRL/ADDR/LEN[/payload], runs the transfer, and appends a status byte.
module i2c_bridge_ctrl #(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    ADDR_WIDTH    = 7,
    parameter int                    NUM_BUS       = 4,
    parameter int                    MAX_LEN       = 16,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE     = 8'hA5,
    parameter int                    XFER_TIMEOUT  = 100000,
    parameter int                    FRAME_TIMEOUT = 1000000,
    localparam int                   BW            = (NUM_BUS > 1) ? $clog2(NUM_BUS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  f_empty,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic                  fifo_read_en,
    output logic [DATA_WIDTH-1:0] i2c_data,
    output logic [ADDR_WIDTH-1:0] i2c_slv_addr,
    output logic [DATA_WIDTH-1:0] num_byte,
    output logic                  rw,
    output logic                  en,
    output logic [BW-1:0]         bus_sel,
    input  logic                  en_ack,
    input  logic                  i2c_busy,
    input  logic                  data_valid_out,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_wr_data
);

    localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [DATA_WIDTH-1:0] ST_OK    = DATA_WIDTH'(8'h00);
    localparam logic [DATA_WIDTH-1:0] ST_BUS   = DATA_WIDTH'(8'h02);
    localparam logic [DATA_WIDTH-1:0] ST_LEN   = DATA_WIDTH'(8'h03);
    localparam logic [DATA_WIDTH-1:0] ST_XFER  = DATA_WIDTH'(8'h04);
    localparam logic [DATA_WIDTH-1:0] ST_FRAME = DATA_WIDTH'(8'h05);
    localparam logic [DATA_WIDTH-1:0] ST_OVF   = DATA_WIDTH'(8'h06);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_WAIT, S_PARSE, S_START, S_XFER, S_STATUS
    } state_t;

    state_t                state_q;
    logic [2:0]            idx_q;
    logic                  rw_q;
    logic [2:0]            bus_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] len_q;
    logic [PW-1:0]         wptr_q;
    logic [PW-1:0]         ptr_q;
    logic [DATA_WIDTH-1:0] status_q;
    logic [31:0]           ftmr_q;
    logic [31:0]           wd_q;
    logic                  seen_busy_q;
    logic                  wr_prev_q;
    logic                  fifo_read_en_q;
    logic                  en_q;
    logic [DATA_WIDTH-1:0] i2c_data_q;
    logic [ADDR_WIDTH-1:0] slv_addr_q;
    logic [DATA_WIDTH-1:0] num_byte_q;
    logic                  rw_out_q;
    logic [BW-1:0]         bus_sel_q;
    logic [DATA_WIDTH-1:0] wbuf_q [MAX_LEN];

    logic xfer_push, status_push, len_bad, bus_bad, last_wr, ptr_more;

    assign len_bad  = (fifo_read_data == '0) || (32'(fifo_read_data) > MAX_LEN);
    assign bus_bad  = 32'(bus_q) >= NUM_BUS;
    assign last_wr  = (32'(wptr_q) + 32'd1) == 32'(len_q);
    assign ptr_more = (32'(ptr_q) + 32'd1) < 32'(num_byte_q);

    // Read bytes go out in the cycle they arrive; wr_prev_q keeps the status push off a data push.
    always_comb begin
        xfer_push    = (state_q == S_XFER) && data_valid_out && !fifo_full;
        status_push  = (state_q == S_STATUS) && !fifo_full && !wr_prev_q;
        fifo_wr_en   = xfer_push || status_push;
        fifo_wr_data = '0;
        if (status_push) begin
            fifo_wr_data = status_q;
        end else if (xfer_push) begin
            fifo_wr_data = data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_PARSE && idx_q == 3'd4) begin
            wbuf_q[wptr_q] <= fifo_read_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            rw_q           <= 1'b0;
            bus_q          <= '0;
            addr_q         <= '0;
            len_q          <= '0;
            wptr_q         <= '0;
            ptr_q          <= '0;
            status_q       <= '0;
            ftmr_q         <= '0;
            wd_q           <= '0;
            seen_busy_q    <= 1'b0;
            wr_prev_q      <= 1'b0;
            fifo_read_en_q <= 1'b0;
            en_q           <= 1'b0;
            i2c_data_q     <= '0;
            slv_addr_q     <= '0;
            num_byte_q     <= '0;
            rw_out_q       <= 1'b0;
            bus_sel_q      <= '0;
        end else begin
            fifo_read_en_q <= 1'b0;
            en_q           <= 1'b0;
            wr_prev_q      <= fifo_wr_en;
            unique case (state_q)
                S_IDLE: begin
                    if (!f_empty) begin
                        fifo_read_en_q <= 1'b1;
                        ftmr_q         <= '0;
                        state_q        <= S_RD_WAIT;
                    end else if (idx_q != 3'd0) begin
                        if (ftmr_q == 32'(FRAME_TIMEOUT - 1)) begin
                            status_q <= ST_FRAME;
                            idx_q    <= '0;
                            ftmr_q   <= '0;
                            state_q  <= S_STATUS;
                        end else begin
                            ftmr_q <= ftmr_q + 32'd1;
                        end
                    end
                end
                S_RD_WAIT: state_q <= S_PARSE;
                S_PARSE: begin
                    state_q <= S_IDLE;
                    case (idx_q)
                        3'd0: begin
                            if (fifo_read_data == SYNC_BYTE) begin
                                idx_q    <= 3'd1;
                                status_q <= ST_OK;
                            end
                        end
                        3'd1: begin
                            rw_q  <= fifo_read_data[7];
                            bus_q <= fifo_read_data[6:4];
                            idx_q <= 3'd2;
                        end
                        3'd2: begin
                            addr_q <= fifo_read_data[ADDR_WIDTH-1:0];
                            idx_q  <= 3'd3;
                        end
                        3'd3: begin
                            len_q  <= fifo_read_data;
                            wptr_q <= '0;
                            if (len_bad) begin
                                status_q <= ST_LEN;
                                idx_q    <= '0;
                                state_q  <= S_STATUS;
                            end else if (bus_bad) begin
                                status_q <= ST_BUS;
                                idx_q    <= '0;
                                state_q  <= S_STATUS;
                            end else if (rw_q) begin
                                idx_q   <= '0;
                                state_q <= S_START;
                            end else begin
                                idx_q <= 3'd4;
                            end
                        end
                        default: begin
                            if (last_wr) begin
                                idx_q   <= '0;
                                state_q <= S_START;
                            end else begin
                                wptr_q <= wptr_q + PW'(1);
                            end
                        end
                    endcase
                end
                S_START: begin
                    bus_sel_q   <= BW'(bus_q);
                    slv_addr_q  <= addr_q;
                    rw_out_q    <= rw_q;
                    num_byte_q  <= len_q;
                    i2c_data_q  <= wbuf_q[0];
                    ptr_q       <= '0;
                    wd_q        <= '0;
                    seen_busy_q <= 1'b0;
                    en_q        <= 1'b1;
                    state_q     <= S_XFER;
                end
                S_XFER: begin
                    if (data_valid_out && fifo_full) begin
                        status_q <= ST_OVF;
                    end
                    if (en_ack && ptr_more) begin
                        ptr_q      <= ptr_q + PW'(1);
                        i2c_data_q <= wbuf_q[ptr_q + PW'(1)];
                    end
                    if (i2c_busy) begin
                        seen_busy_q <= 1'b1;
                    end
                    // A timeout overrides an earlier overflow code.
                    if (seen_busy_q && !i2c_busy) begin
                        state_q <= S_STATUS;
                    end else if (en_ack || data_valid_out || (i2c_busy && !seen_busy_q)) begin
                        wd_q <= '0;
                    end else if (wd_q == 32'(XFER_TIMEOUT - 1)) begin
                        status_q <= ST_XFER;
                        state_q  <= S_STATUS;
                    end else begin
                        wd_q <= wd_q + 32'd1;
                    end
                end
                S_STATUS: begin
                    if (status_push) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign fifo_read_en = fifo_read_en_q;
    assign en           = en_q;
    assign i2c_data     = i2c_data_q;
    assign i2c_slv_addr = slv_addr_q;
    assign num_byte     = num_byte_q;
    assign rw           = rw_out_q;
    assign bus_sel      = bus_sel_q;

endmodule

// File: tb/tb_i2c_bridge_ctrl.sv
// tb/tb_i2c_bridge_ctrl.sv - scoreboard bench for i2c_bridge_ctrl
module tb_i2c_bridge_ctrl;

    localparam int XT = 40;
    localparam int FT = 60;

    logic       clk = 1'b0;
    logic       rst;
    logic       f_empty;
    logic [7:0] fifo_read_data;
    logic       fifo_read_en;
    logic [7:0] i2c_data;
    logic [6:0] i2c_slv_addr;
    logic [7:0] num_byte;
    logic       rw;
    logic       en;
    logic [1:0] bus_sel;
    logic       en_ack;
    logic       i2c_busy;
    logic       data_valid_out;
    logic [7:0] data_out;
    logic       fifo_full;
    logic       fifo_wr_en;
    logic [7:0] fifo_wr_data;

    always #5 clk = ~clk;

    i2c_bridge_ctrl #(.XFER_TIMEOUT(XT), .FRAME_TIMEOUT(FT)) dut (
        .clk(clk), .rst(rst), .f_empty(f_empty), .fifo_read_data(fifo_read_data),
        .fifo_read_en(fifo_read_en), .i2c_data(i2c_data), .i2c_slv_addr(i2c_slv_addr),
        .num_byte(num_byte), .rw(rw), .en(en), .bus_sel(bus_sel), .en_ack(en_ack),
        .i2c_busy(i2c_busy), .data_valid_out(data_valid_out), .data_out(data_out),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data)
    );

    typedef struct packed {
        logic [1:0] bus;
        logic       rw;
        logic [6:0] addr;
        logic [7:0] len;
    } start_t;

    logic [7:0] rxq[$];
    logic [7:0] exp_resp[$];
    start_t     exp_start[$];
    int errors = 0;
    int checks = 0;
    int en_cnt = 0;
    int base;

    function automatic start_t mk_start(input logic [1:0] b, input logic r,
                                        input logic [6:0] a, input logic [7:0] l);
        start_t s;
        s.bus = b; s.rw = r; s.addr = a; s.len = l;
        return s;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic monitor;
        start_t s;
        forever begin
            @(negedge clk);
            if (fifo_wr_en) begin
                if (exp_resp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL resp_unexpected got=%0h exp=none", fifo_wr_data);
                end else begin
                    check("resp_byte", 64'(fifo_wr_data), 64'(exp_resp.pop_front()));
                end
            end
            if (en) begin
                en_cnt++;
                if (exp_start.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL en_unexpected got=%0h exp=none", {bus_sel, rw, i2c_slv_addr, num_byte});
                end else begin
                    s = exp_start.pop_front();
                    check("start_fields", 64'({bus_sel, rw, i2c_slv_addr, num_byte}), 64'(s));
                end
            end
            if (fifo_read_en) check("rd_nonempty", 64'(f_empty), 64'(0));
        end
    endtask

    task automatic fifo_model;
        logic [7:0] nxt;
        forever begin
            @(posedge clk);
            if (fifo_read_en && rxq.size() > 0) begin
                nxt = rxq.pop_front();
                #1 fifo_read_data = nxt;
            end else begin
                #1;
            end
            f_empty = (rxq.size() == 0);
        end
    endtask

    task automatic send4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        rxq.push_back(a); rxq.push_back(b); rxq.push_back(c); rxq.push_back(d);
    endtask

    task automatic wait_en(input int b);
        int n = 0;
        while (en_cnt == b && n < 100) begin tick; n++; end
        check("en_seen", 64'(en_cnt != b), 64'(1));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_resp.size() != 0 || exp_start.size() != 0) && n < budget) begin tick; n++; end
        check("drain", 64'(exp_resp.size() + exp_start.size()), 64'(0));
    endtask

    task automatic ack(input logic [7:0] e);
        en_ack = 1'b1;
        tick;
        en_ack = 1'b0;
        check("i2c_data", 64'(i2c_data), 64'(e));
    endtask

    task automatic dv(input logic [7:0] b);
        data_valid_out = 1'b1;
        data_out = b;
        tick;
        data_valid_out = 1'b0;
        tick;
    endtask

    initial begin
        rst = 1'b1; f_empty = 1'b1; fifo_read_data = '0; en_ack = 1'b0;
        i2c_busy = 1'b0; data_valid_out = 1'b0; data_out = '0; fifo_full = 1'b0;
        fork
            monitor();
            fifo_model();
        join_none
        repeat (3) tick;
        check("reset_outs", 64'({fifo_read_en, en, fifo_wr_en, rw, bus_sel, i2c_slv_addr,
                                 num_byte, i2c_data, fifo_wr_data}), 64'(0));
        rst = 1'b0;
        tick;

        // write of 3 bytes on bus 2; extra en_ack holds last byte
        base = en_cnt;
        exp_start.push_back(mk_start(2'd2, 1'b0, 7'h50, 8'd3));
        exp_resp.push_back(8'h00);
        send4(8'hA5, 8'h20, 8'h50, 8'h03);
        rxq.push_back(8'h11); rxq.push_back(8'h22); rxq.push_back(8'h33);
        wait_en(base);
        check("i2c_data_first", 64'(i2c_data), 64'(8'h11));
        i2c_busy = 1'b1;
        tick;
        ack(8'h22);
        ack(8'h33);
        ack(8'h33);
        tick;
        i2c_busy = 1'b0;
        drain(100);

        // read of 2 bytes on bus 0
        base = en_cnt;
        exp_start.push_back(mk_start(2'd0, 1'b1, 7'h3C, 8'd2));
        exp_resp.push_back(8'hAB); exp_resp.push_back(8'hCD); exp_resp.push_back(8'h00);
        send4(8'hA5, 8'h81, 8'h3C, 8'h02);
        wait_en(base);
        i2c_busy = 1'b1;
        tick; tick;
        dv(8'hAB);
        dv(8'hCD);
        i2c_busy = 1'b0;
        drain(100);

        // garbage byte then bad bus
        exp_resp.push_back(8'h02);
        rxq.push_back(8'h5A);
        send4(8'hA5, 8'h70, 8'h10, 8'h01);
        drain(100);

        // LEN 0 and LEN 17
        exp_resp.push_back(8'h03);
        send4(8'hA5, 8'h00, 8'h50, 8'h00);
        drain(100);
        exp_resp.push_back(8'h03);
        send4(8'hA5, 8'h00, 8'h50, 8'h11);
        drain(100);

        // LEN 16 on highest bus is accepted
        base = en_cnt;
        exp_start.push_back(mk_start(2'd3, 1'b1, 7'h7F, 8'd16));
        exp_resp.push_back(8'h00);
        send4(8'hA5, 8'hB0, 8'h7F, 8'h10);
        wait_en(base);
        i2c_busy = 1'b1;
        tick;
        i2c_busy = 1'b0;
        drain(100);

        // stalled master -> watchdog
        base = en_cnt;
        exp_start.push_back(mk_start(2'd0, 1'b1, 7'h22, 8'd1));
        exp_resp.push_back(8'h04);
        send4(8'hA5, 8'h80, 8'h22, 8'h01);
        wait_en(base);
        repeat (20) tick;
        check("xfer_to_early", 64'(exp_resp.size()), 64'(1));
        drain(200);

        // truncated frame -> frame timeout
        exp_resp.push_back(8'h05);
        rxq.push_back(8'hA5); rxq.push_back(8'h00);
        repeat (20) tick;
        check("frame_to_early", 64'(exp_resp.size()), 64'(1));
        drain(300);

        // read of 4 with overflow on the 3rd byte
        base = en_cnt;
        exp_start.push_back(mk_start(2'd1, 1'b1, 7'h11, 8'd4));
        exp_resp.push_back(8'h01); exp_resp.push_back(8'h02);
        exp_resp.push_back(8'h04); exp_resp.push_back(8'h06);
        send4(8'hA5, 8'h90, 8'h11, 8'h04);
        wait_en(base);
        i2c_busy = 1'b1;
        tick;
        dv(8'h01);
        dv(8'h02);
        fifo_full = 1'b1;
        dv(8'h03);
        fifo_full = 1'b0;
        dv(8'h04);
        fifo_full = 1'b1;
        i2c_busy = 1'b0;
        repeat (5) tick;
        check("status_held_full", 64'(exp_resp.size()), 64'(1));
        fifo_full = 1'b0;
        drain(100);

        // reset mid-transfer: no status byte afterwards
        base = en_cnt;
        exp_start.push_back(mk_start(2'd0, 1'b1, 7'h44, 8'd2));
        exp_resp.push_back(8'h77);
        send4(8'hA5, 8'h80, 8'h44, 8'h02);
        wait_en(base);
        i2c_busy = 1'b1;
        tick;
        dv(8'h77);
        rst = 1'b1;
        tick;
        check("reset_mid_outs", 64'({fifo_read_en, en, fifo_wr_en, rw, bus_sel, i2c_slv_addr,
                                     num_byte, i2c_data, fifo_wr_data}), 64'(0));
        rst = 1'b0;
        i2c_busy = 1'b0;
        repeat (20) tick;
        check("queues_empty", 64'(exp_resp.size() + exp_start.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
